mem_bus_master: RTL and testbench
=================================

# mem_bus_master

Bus initiator that drives the 256-word memory-mapped RAM/IO responder (en/wrt/done interface) on behalf of the CPU load/store path. Accepts one byte-, halfword- or word-sized load/store per handshake, checks alignment and address range, performs read-modify-write for sub-word stores, and returns a one-cycle response pulse with data or error. It owns all sequencing of the responder's active-low `en` strobe and its `done` acknowledge, including a timeout.

## Interface
- `TIMEOUT`, 15: cycles to wait for `bus_done` in a request state before aborting with error.
- `clk` in 1: system clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cpu_req_valid` in 1: request present.
- `cpu_req_ready` out 1: high only in IDLE; a request is accepted on an edge where valid & ready.
- `cpu_req_wr` in 1: 1 = store, 0 = load.
- `cpu_req_size` in 2: 00 byte, 01 halfword, 10 word, 11 illegal (error).
- `cpu_req_addr` in 32: byte address.
- `cpu_req_wdata` in 32: store data, right-justified for sub-word sizes.
- `cpu_rsp_valid` out 1: one-cycle response pulse, no backpressure.
- `cpu_rsp_rdata` out 32: load data, zero-extended; 0 for stores and errors.
- `cpu_rsp_err` out 1: valid with `cpu_rsp_valid`.
- `bus_addr` out 32: word index `{24'b0, cpu_req_addr[9:2]}`.
- `bus_d` out 32: write data to responder.
- `bus_en` out 1: active-low access strobe; 1 = idle.
- `bus_wrt` out 1: 1 = write, 0 = read, meaningful while `bus_en`=0.
- `bus_q` in 32: read data from responder.
- `bus_done` in 1: responder acknowledge; forced 0 by responder while `bus_en`=1.

## Operation
- States: IDLE, RD_REQ, RMW_GAP, WR_REQ, RESP.
- Acceptance checks (in IDLE, at accept edge): error if size=11, halfword with addr[0]=1, word with addr[1:0]≠0, addr[31:10]≠0, or store to word 129 (switch input, read-only). Error → RESP with err=1, no bus access.
- Load (any size) → RD_REQ. Word store → WR_REQ. Byte/halfword store → RD_REQ (RMW).
- RD_REQ: `bus_en`=0, `bus_wrt`=0. On edge with `bus_done`=1: capture `bus_q`; load → RESP; RMW → merge store lane into captured word, → RMW_GAP.
- RMW_GAP: `bus_en`=1 for exactly one cycle (lets `done` drop), → WR_REQ.
- WR_REQ: `bus_en`=0, `bus_wrt`=1, `bus_d` = full or merged word. On `bus_done`=1 → RESP.
- RESP: `bus_en`=1, `cpu_rsp_valid`=1 for one cycle, → IDLE.
- Lanes: byte lane = addr[1:0], halfword lane = addr[1]; load extracts lane and zero-extends; store replaces only that lane.
- Timeout: cycle counter cleared on entry to RD_REQ/WR_REQ; if `bus_done` still 0 on the `TIMEOUT`-th cycle in that state → RESP with err=1, rdata=0; an RMW timing out in RD_REQ never writes.
- `bus_addr`, `bus_wrt`, `bus_d` held stable for the entire time `bus_en`=0.

## Timing
- All outputs registered except `cpu_req_ready` (decode of state==IDLE).
- Reset values: `bus_en`=1, `bus_wrt`=0, `bus_addr`=0, `bus_d`=0, `cpu_rsp_valid`=0, `cpu_rsp_rdata`=0, `cpu_rsp_err`=0, state IDLE, counter 0.
- Accept at edge E0; with `done` returned same cycle: word load/store → `bus_en`=0 cycle E0–E1, rsp_valid cycle E1–E2. RMW store → rsp_valid cycle E3–E4. Error → rsp_valid cycle E0–E1.
- `bus_en` always returns to 1 for ≥1 cycle between any two accesses (RESP or RMW_GAP guarantees it); back-to-back requests: next accept earliest at edge ending RESP+1 cycle in IDLE.
- `rst` asserted in any state: next edge all outputs to reset values, in-flight request dropped, no response issued.
- `bus_done`=1 while `bus_en`=1 is ignored.

## Structure
- Package `mem_bus_pkg`: size encodings, state enum, `MAP_WORDS`=256, `LED_WORD`=128, `SW_WORD`=129, `SEG_WORD`=192.
- Sub-module `byte_lane_unit`: combinational load extract/zero-extend and store merge, given size, addr[1:0], word, wdata.
- Top holds FSM, timeout counter, request/capture registers.

## Test plan
- Word store 0xDEADBEEF to byte addr 0x200 (word 128), then word load → rsp err=0, rdata=0xDEADBEEF; `bus_addr`=128 during both accesses; LED word updated.
- Byte store 0xAB to addr 0x001 over word 0x11223344 → read then write of 0x1122AB44, gap cycle with `bus_en`=1 observed; rsp at 4th cycle after accept.
- Halfword load from addr 0x002 holding 0xCAFE1234 → rdata=0x0000CAFE.
- Misaligned word at 0x002, size=11, addr 0x400, store to 0x204 → each err=1 next cycle, `bus_en` never 0.
- Responder holds `done`=0 → after 15 cycles in RD_REQ, rsp err=1, rdata=0, `bus_en`=1; RMW variant issues no write.
- `rst` pulsed during WR_REQ → next cycle `bus_en`=1, no `cpu_rsp_valid`, `cpu_req_ready`=1.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared types and constants for the memory bus initiator
//
// Access size encoding, FSM state enum, memory map constants and the
// request legality check used at the accept edge.
package mem_bus_pkg;

  localparam int         MAP_WORDS = 256;
  localparam logic [7:0] LED_WORD  = 8'd128;
  localparam logic [7:0] SW_WORD   = 8'd129;
  localparam logic [7:0] SEG_WORD  = 8'd192;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_BAD  = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RMW_GAP,
    ST_WR_REQ,
    ST_RESP
  } state_e;

  // True when a request must be rejected without touching the bus.
  // The switch word is an input port, so any store to it is refused.
  function automatic logic req_illegal(input logic wr, input logic [1:0] size,
                                       input logic [31:0] addr);
    logic misaligned;
    misaligned = (size == SIZE_HALF && addr[0]) ||
                 (size == SIZE_WORD && addr[1:0] != 2'b00);
    return (size == SIZE_BAD) || misaligned ||
           (addr[31:2] >= 30'(MAP_WORDS)) ||
           (wr && addr[9:2] == SW_WORD);
  endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// rtl/byte_lane_unit.sv - sub-word load extract and store merge
//
// Purely combinational.
//   size  : access size of the pending request
//   lane  : byte address bits [1:0] of the request
//   word  : full word returned by the responder
//   wdata : right-justified store data
//   rdata : selected lane of word, zero-extended
//   merged: word with only the addressed lane replaced by wdata
module byte_lane_unit
  import mem_bus_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] merged
);

  always_comb begin
    rdata  = word;
    merged = wdata;
    case (size)
      SIZE_BYTE: begin
        rdata  = {24'b0, word[{lane, 3'b000} +: 8]};
        merged = word;
        merged[{lane, 3'b000} +: 8] = wdata[7:0];
      end
      SIZE_HALF: begin
        rdata  = {16'b0, word[{lane[1], 4'b0000} +: 16]};
        merged = word;
        merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_bus_master.sv
// rtl/mem_bus_master.sv - CPU load/store initiator for the en/wrt/done responder
//
// Accepts one load/store per valid/ready handshake, rejects illegal ones,
// performs read-modify-write for byte/halfword stores and returns a single
// cycle response. All outputs are registered except cpu_req_ready.
//   cpu_req_*     : request (valid/ready, wr, size, byte addr, wdata)
//   cpu_rsp_*     : response pulse (valid, rdata, err), no backpressure
//   bus_addr/d    : word index and write data to the responder
//   bus_en/wrt    : active-low strobe and write flag
//   bus_q/done    : responder read data and acknowledge
module mem_bus_master
  import mem_bus_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req_valid,
  output logic        cpu_req_ready,
  input  logic        cpu_req_wr,
  input  logic [1:0]  cpu_req_size,
  input  logic [31:0] cpu_req_addr,
  input  logic [31:0] cpu_req_wdata,
  output logic        cpu_rsp_valid,
  output logic [31:0] cpu_rsp_rdata,
  output logic        cpu_rsp_err,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_d,
  output logic        bus_en,
  output logic        bus_wrt,
  input  logic [31:0] bus_q,
  input  logic        bus_done
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e        state;
  logic [CW-1:0] cnt;
  logic          req_wr;
  size_e         req_size;
  logic [1:0]    req_lane;
  logic [31:0]   req_wdata;
  logic [31:0]   lane_rdata;
  logic [31:0]   lane_merged;
  logic          timed_out;

  assign cpu_req_ready = (state == ST_IDLE);
  // cnt counts completed cycles in the request state; this is the last one.
  assign timed_out     = (cnt == CW'(TIMEOUT - 1));

  byte_lane_unit u_lane (
    .size   (req_size),
    .lane   (req_lane),
    .word   (bus_q),
    .wdata  (req_wdata),
    .rdata  (lane_rdata),
    .merged (lane_merged)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      req_wr        <= 1'b0;
      req_size      <= SIZE_BYTE;
      req_lane      <= 2'b00;
      req_wdata     <= '0;
      bus_en        <= 1'b1;
      bus_wrt       <= 1'b0;
      bus_addr      <= '0;
      bus_d         <= '0;
      cpu_rsp_valid <= 1'b0;
      cpu_rsp_rdata <= '0;
      cpu_rsp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cpu_req_valid) begin
            req_wr    <= cpu_req_wr;
            req_size  <= size_e'(cpu_req_size);
            req_lane  <= cpu_req_addr[1:0];
            req_wdata <= cpu_req_wdata;
            if (req_illegal(cpu_req_wr, cpu_req_size, cpu_req_addr)) begin
              cpu_rsp_valid <= 1'b1;
              cpu_rsp_err   <= 1'b1;
              cpu_rsp_rdata <= '0;
              state         <= ST_RESP;
            end else begin
              bus_addr <= {24'b0, cpu_req_addr[9:2]};
              bus_en   <= 1'b0;
              cnt      <= '0;
              if (cpu_req_wr && cpu_req_size == SIZE_WORD) begin
                bus_wrt <= 1'b1;
                bus_d   <= cpu_req_wdata;
                state   <= ST_WR_REQ;
              end else begin
                // Loads and sub-word stores both start with a read.
                bus_wrt <= 1'b0;
                state   <= ST_RD_REQ;
              end
            end
          end
        end
        ST_RD_REQ: begin
          if (bus_done) begin
            bus_en <= 1'b1;
            if (req_wr) begin
              bus_d <= lane_merged;
              state <= ST_RMW_GAP;
            end else begin
              cpu_rsp_valid <= 1'b1;
              cpu_rsp_err   <= 1'b0;
              cpu_rsp_rdata <= lane_rdata;
              state         <= ST_RESP;
            end
          end else if (timed_out) begin
            bus_en        <= 1'b1;
            cpu_rsp_valid <= 1'b1;
            cpu_rsp_err   <= 1'b1;
            cpu_rsp_rdata <= '0;
            state         <= ST_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RMW_GAP: begin
          // One idle cycle so the responder drops done before the write.
          bus_en  <= 1'b0;
          bus_wrt <= 1'b1;
          cnt     <= '0;
          state   <= ST_WR_REQ;
        end
        ST_WR_REQ: begin
          if (bus_done || timed_out) begin
            bus_en        <= 1'b1;
            cpu_rsp_valid <= 1'b1;
            cpu_rsp_err   <= ~bus_done;
            cpu_rsp_rdata <= '0;
            state         <= ST_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RESP: begin
          cpu_rsp_valid <= 1'b0;
          cpu_rsp_err   <= 1'b0;
          cpu_rsp_rdata <= '0;
          state         <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_master.sv
// tb/tb_mem_bus_master.sv - self-checking bench for mem_bus_master
module tb_mem_bus_master;
  import mem_bus_pkg::*;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req_valid;
  logic        cpu_req_ready;
  logic        cpu_req_wr;
  logic [1:0]  cpu_req_size;
  logic [31:0] cpu_req_addr;
  logic [31:0] cpu_req_wdata;
  logic        cpu_rsp_valid;
  logic [31:0] cpu_rsp_rdata;
  logic        cpu_rsp_err;
  logic [31:0] bus_addr;
  logic [31:0] bus_d;
  logic        bus_en;
  logic        bus_wrt;
  logic [31:0] bus_q;
  logic        bus_done;

  always #5 clk = ~clk;

  mem_bus_master #(.TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_req_valid (cpu_req_valid),
    .cpu_req_ready (cpu_req_ready),
    .cpu_req_wr    (cpu_req_wr),
    .cpu_req_size  (cpu_req_size),
    .cpu_req_addr  (cpu_req_addr),
    .cpu_req_wdata (cpu_req_wdata),
    .cpu_rsp_valid (cpu_rsp_valid),
    .cpu_rsp_rdata (cpu_rsp_rdata),
    .cpu_rsp_err   (cpu_rsp_err),
    .bus_addr      (bus_addr),
    .bus_d         (bus_d),
    .bus_en        (bus_en),
    .bus_wrt       (bus_wrt),
    .bus_q         (bus_q),
    .bus_done      (bus_done)
  );

  // Responder: acknowledges in the same cycle unless stalled.
  logic [31:0] mem [256] = '{default: 32'h0};
  logic        stall = 1'b0;
  int          wr_count = 0;
  int          cyc = 0;

  assign bus_done = !bus_en && !stall;
  assign bus_q    = mem[bus_addr[7:0]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!bus_en && bus_wrt && bus_done) begin
      mem[bus_addr[7:0]] <= bus_d;
      wr_count <= wr_count + 1;
    end
  end

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          n_acc;
    int          n_wr;
    logic [7:0]  idx;
    int          cyc;
  } exp_t;

  logic [31:0] ref_mem [256] = '{default: 32'h0};
  exp_t        exp_q[$];
  int          rd_idx = 0;
  int          checks = 0;
  int          failures = 0;
  logic        prev_en = 1'b1;
  logic        prev_wrt = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  logic [31:0] prev_d = 32'h0;
  int          acc_cnt = 0;
  int          wr_base = 0;
  int          last_lat = 0;
  logic [31:0] last_rdata = 32'h0;
  logic        last_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Expected outcome of one request, straight from the access rules.
  task automatic model(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                       input logic [31:0] wdata, output exp_t e);
    logic [31:0] mask;
    logic [31:0] old;
    int          sh;
    bit          bad;
    e.idx   = addr[9:2];
    e.err   = 1'b0;
    e.rdata = 32'h0;
    e.n_wr  = 0;
    e.cyc   = 0;
    bad = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
          (size == 2'b10 && addr[1:0] != 2'b00) || (addr >= 32'h400) ||
          (wr && addr[9:2] == SW_WORD);
    mask = (size == 2'b00) ? 32'hFF : (size == 2'b01) ? 32'hFFFF : 32'hFFFF_FFFF;
    sh   = 8 * int'(addr[1:0]);
    old  = ref_mem[e.idx];
    if (bad) begin
      e.err = 1'b1; e.lat = 1; e.n_acc = 0;
    end else if (stall) begin
      e.err = 1'b1; e.lat = TO + 1; e.n_acc = 1;
    end else if (!wr) begin
      e.rdata = (old >> sh) & mask; e.lat = 2; e.n_acc = 1;
    end else begin
      ref_mem[e.idx] = (old & ~(mask << sh)) | ((wdata & mask) << sh);
      e.n_wr  = 1;
      e.n_acc = (size == 2'b10) ? 1 : 2;
      e.lat   = (size == 2'b10) ? 2 : 4;
    end
  endtask

  // Per-cycle compare against the pending expectation.
  task automatic check_cycle();
    exp_t e;
    if (!bus_en && !prev_en) begin
      chk("bus_addr_hold", bus_addr, prev_addr);
      chk("bus_wrt_hold", 32'(bus_wrt), 32'(prev_wrt));
      chk("bus_d_hold", bus_d, prev_d);
    end
    if (!bus_en && prev_en) acc_cnt++;
    if (rd_idx < exp_q.size()) begin
      e = exp_q[rd_idx];
      if (!bus_en) begin
        if (e.n_acc == 0) chk("no_bus_on_error", 32'(bus_en), 32'd1);
        else chk("bus_addr", bus_addr, {24'b0, e.idx});
      end
      if (cpu_rsp_valid) begin
        chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
        chk("rsp_err", 32'(cpu_rsp_err), 32'(e.err));
        chk("rsp_rdata", cpu_rsp_rdata, e.rdata);
        chk("bus_accesses", 32'(acc_cnt), 32'(e.n_acc));
        chk("bus_writes", 32'(wr_count - wr_base), 32'(e.n_wr));
        chk("rsp_bus_idle", 32'(bus_en), 32'd1);
        last_lat   = cyc - (e.cyc - e.lat);
        last_rdata = cpu_rsp_rdata;
        last_err   = cpu_rsp_err;
        rd_idx++;
        acc_cnt = 0;
        wr_base = wr_count;
      end else if (cyc > e.cyc) begin
        chk("rsp_missing", 32'(cpu_rsp_valid), 32'd1);
        rd_idx++;
        acc_cnt = 0;
        wr_base = wr_count;
      end
    end else begin
      chk("rsp_spurious", 32'(cpu_rsp_valid), 32'd0);
    end
    prev_en   = bus_en;
    prev_wrt  = bus_wrt;
    prev_addr = bus_addr;
    prev_d    = bus_d;
  endtask

  task automatic tick();
    @(negedge clk);
    check_cycle();
  endtask

  task automatic issue(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                       input logic [31:0] wdata);
    exp_t e;
    int   n;
    cpu_req_valid = 1'b1;
    cpu_req_wr    = wr;
    cpu_req_size  = size;
    cpu_req_addr  = addr;
    cpu_req_wdata = wdata;
    n = 0;
    while (!cpu_req_ready && n < 40) begin tick(); n++; end
    if (!cpu_req_ready) begin
      chk("req_ready_timeout", 32'(cpu_req_ready), 32'd1);
      cpu_req_valid = 1'b0;
      return;
    end
    model(wr, size, addr, wdata, e);
    e.cyc = cyc + e.lat;
    exp_q.push_back(e);
    tick();
    cpu_req_valid = 1'b0;
    n = 0;
    while (rd_idx < exp_q.size() && n < 40) begin tick(); n++; end
    if (rd_idx < exp_q.size()) begin
      chk("rsp_wait_timeout", 32'(rd_idx), 32'(exp_q.size()));
      rd_idx = exp_q.size();
    end
  endtask

  initial begin
    int wc;
    rst           = 1'b1;
    cpu_req_valid = 1'b0;
    cpu_req_wr    = 1'b0;
    cpu_req_size  = 2'b00;
    cpu_req_addr  = 32'h0;
    cpu_req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_bus_en", 32'(bus_en), 32'd1);
    chk("rst_bus_wrt", 32'(bus_wrt), 32'd0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_bus_d", bus_d, 32'h0);
    chk("rst_rsp_valid", 32'(cpu_rsp_valid), 32'd0);
    chk("rst_rsp_rdata", cpu_rsp_rdata, 32'h0);
    chk("rst_rsp_err", 32'(cpu_rsp_err), 32'd0);
    chk("rst_ready", 32'(cpu_req_ready), 32'd1);
    rst = 1'b0;
    tick();

    // Word store / load through the LED word
    issue(1'b1, 2'b10, 32'h200, 32'hDEADBEEF);
    chk("lit_wst_lat", 32'(last_lat), 32'd2);
    chk("lit_led_word", mem[LED_WORD], 32'hDEADBEEF);
    issue(1'b0, 2'b10, 32'h200, 32'h0);
    chk("lit_wld_rdata", last_rdata, 32'hDEADBEEF);
    chk("lit_wld_lat", 32'(last_lat), 32'd2);

    // Byte RMW store
    issue(1'b1, 2'b10, 32'h000, 32'h11223344);
    issue(1'b1, 2'b00, 32'h001, 32'h000000AB);
    chk("lit_rmw_word", mem[0], 32'h1122AB44);
    chk("lit_rmw_lat", 32'(last_lat), 32'd4);

    // Halfword / byte loads and more sub-word stores
    issue(1'b1, 2'b10, 32'h000, 32'hCAFE1234);
    issue(1'b0, 2'b01, 32'h002, 32'h0);
    chk("lit_hld_rdata", last_rdata, 32'h0000CAFE);
    issue(1'b0, 2'b00, 32'h003, 32'h0);
    chk("lit_bld_rdata", last_rdata, 32'h000000CA);
    issue(1'b1, 2'b01, 32'h000, 32'hFFFFBEEF);
    chk("lit_hst_word", mem[0], 32'hCAFEBEEF);
    issue(1'b1, 2'b00, 32'h202, 32'h00000055);
    chk("lit_bst_word", mem[LED_WORD], 32'hDE55BEEF);
    issue(1'b0, 2'b00, 32'h200, 32'h0);
    issue(1'b1, 2'b01, 32'h30E, 32'h0000A5A5);
    issue(1'b0, 2'b10, 32'h30C, 32'h0);
    issue(1'b0, 2'b10, 32'h204, 32'h0);

    // Rejected requests
    issue(1'b0, 2'b10, 32'h002, 32'h0);
    chk("lit_err_lat", 32'(last_lat), 32'd1);
    chk("lit_err_flag", 32'(last_err), 32'd1);
    issue(1'b0, 2'b11, 32'h000, 32'h0);
    issue(1'b0, 2'b10, 32'h400, 32'h0);
    issue(1'b1, 2'b10, 32'h204, 32'h12345678);
    issue(1'b1, 2'b01, 32'h001, 32'h0);
    issue(1'b1, 2'b00, 32'h205, 32'h0);

    // Responder never acknowledges
    stall = 1'b1;
    issue(1'b0, 2'b10, 32'h200, 32'h0);
    chk("lit_to_lat", 32'(last_lat), 32'(TO + 1));
    chk("lit_to_err", 32'(last_err), 32'd1);
    chk("lit_to_rdata", last_rdata, 32'h0);
    issue(1'b1, 2'b00, 32'h200, 32'h00000077);
    stall = 1'b0;
    chk("lit_to_rmw_nowrite", mem[LED_WORD], 32'hDE55BEEF);
    tick();

    // Reset while a word store waits in WR_REQ
    wc = wr_count;
    stall = 1'b1;
    cpu_req_valid = 1'b1;
    cpu_req_wr    = 1'b1;
    cpu_req_size  = 2'b10;
    cpu_req_addr  = 32'h014;
    cpu_req_wdata = 32'h87654321;
    for (int i = 0; i < 5 && !cpu_req_ready; i++) tick();
    tick();
    cpu_req_valid = 1'b0;
    tick();
    chk("wr_req_en", 32'(bus_en), 32'd0);
    chk("wr_req_wrt", 32'(bus_wrt), 32'd1);
    rst = 1'b1;
    tick();
    chk("rst_mid_en", 32'(bus_en), 32'd1);
    chk("rst_mid_rsp", 32'(cpu_rsp_valid), 32'd0);
    chk("rst_mid_ready", 32'(cpu_req_ready), 32'd1);
    chk("rst_mid_addr", bus_addr, 32'h0);
    rst = 1'b0;
    stall = 1'b0;
    repeat (20) tick();
    chk("rst_mid_nowrite", 32'(wr_count), 32'(wc));
    acc_cnt = 0;
    wr_base = wr_count;
    issue(1'b0, 2'b10, 32'h014, 32'h0);
    issue(1'b0, 2'b10, 32'h000, 32'h0);

    for (int i = 0; i < 256; i++) chk($sformatf("mem_%0d", i), mem[i], ref_mem[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
